rv32i_pipe_ctrl: RTL and testbench
==================================

# rv32i_pipe_ctrl

Pipeline hazard and sequencing controller for the 5-stage RV32I core. Decodes register usage of the ID-stage instruction and compares it against the EX stage to detect load-use hazards. Arbitrates stall, flush and freeze between load-use, EX-stage redirects (branch/JAL/JALR), instruction-fetch wait and data-memory wait. Drives the per-stage enable/flush strobes and maintains performance counters. It sits beside the ID stage and feeds every pipeline register plus the PC.

## Interface
- MEM_TIMEOUT, 255: maximum consecutive data-memory wait cycles before the error state; legal range 1..65535.
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- id_instr  in  32  instruction currently in IF/ID.
- id_valid  in  1  IF/ID holds a real instruction.
- ex_valid  in  1  ID/EX holds a real instruction.
- ex_is_load  in  1  EX instruction is a load.
- ex_rd  in  5  EX destination register.
- ex_redirect  in  1  EX resolved a taken branch, JAL or JALR.
- imem_ready  in  1  fetch data valid this cycle.
- dmem_req  in  1  MEM stage issues a load/store this cycle.
- dmem_ready  in  1  data memory completes this cycle.
- pc_en  out  1  PC register update enable.
- pc_sel_redirect  out  1  PC loads the EX target instead of PC+4.
- ifid_en  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads a bubble (valid=0).
- idex_en  out  1  ID/EX load enable.
- idex_flush  out  1  ID/EX loads a bubble.
- exmem_en  out  1  EX/MEM load enable.
- memwb_flush  out  1  MEM/WB loads a bubble.
- mem_timeout  out  1  sticky error flag.
- stall_cycles  out  32  count of cycles with pc_en=0.
- flush_events  out  32  count of redirects applied.

## Operation
- Register usage by opcode (id_instr[6:0]):
  - 0110011, 0100011 and 1100011 use rs1 (bits 19:15) and rs2 (bits 24:20).
  - 0010011, 0000011 and 1100111 use rs1 only.
  - 0110111, 0010111, 1101111 and all other opcodes use no registers.
- x0 never hazards.
- load_use = id_valid & ex_valid & ex_is_load & ex_rd≠0 & (used rs1==ex_rd | used rs2==ex_rd).
- FSM states:
  - INIT: first cycle after reset. All enables 0, ifid_flush=1, idex_flush=1, memwb_flush=1. Always goes to RUN.
  - RUN: normal flow. Default outputs are all enables 1, all flushes 0, pc_sel_redirect=0. Priority, highest first:
    - Data wait (dmem_req & !dmem_ready): pc_en=ifid_en=idex_en=exmem_en=0, memwb_flush=1. Next state MEM_WAIT, wait_cnt←1.
    - Redirect (ex_redirect): pc_en=1, pc_sel_redirect=1, ifid_flush=1, idex_flush=1. Applies regardless of imem_ready or load_use.
    - Load-use: pc_en=0, ifid_en=0, idex_flush=1. Exactly one bubble.
    - Fetch wait (!imem_ready): pc_en=0, ifid_flush=1; downstream stages advance.
  - MEM_WAIT:
    - If dmem_ready: RUN-state evaluation applies this same cycle, treating the data wait as resolved. Next state RUN.
    - Otherwise: freeze outputs as for data wait, and wait_cnt increments. When wait_cnt reaches MEM_TIMEOUT, go to ERR.
  - ERR: all enables 0, memwb_flush=1, mem_timeout=1. Left only by rst.
- A redirect arriving during a freeze is held by the frozen ID/EX/EX stages and applied on the release cycle; no internal pending storage.
- Counters: stall_cycles increments on every cycle with pc_en=0, including INIT and ERR. flush_events increments on every cycle with pc_sel_redirect=1. Both wrap modulo 2^32.
- wait_cnt is 16 bits.

## Timing
- All outputs are combinational from state plus inputs (Mealy); state, wait_cnt and counters are registered on the rising edge of clk.
- Reset: state=INIT, wait_cnt=0, mem_timeout=0, stall_cycles=0, flush_events=0.
- During rst=1, outputs take their INIT values.
- Reset asserted mid-wait or in ERR returns to INIT on the next edge.
- Load-use costs 1 cycle. Redirect costs 2 bubbles. Data wait costs N cycles for N cycles of dmem_ready=0.
- ERR is entered on the edge where wait_cnt would exceed MEM_TIMEOUT-1, i.e. after MEM_TIMEOUT consecutive not-ready cycles including the RUN entry cycle.
- Counter updates become visible one cycle after the qualifying cycle.

## Test plan
- Load-use detection: ex: lw x5 (ex_is_load=1, ex_rd=5); id: add x6,x5,x1 (0x00128333).
  - Expect one cycle of pc_en=0, ifid_en=0, idex_flush=1, then normal flow.
  - stall_cycles = 1 plus the INIT cycle.
- No false hazards:
  - Same EX load with id = lui x5 (0x000052b7): no stall.
  - Same EX load with id = addi x6,x0,1 while ex_rd=0: no stall.
- Redirect beats load-use and fetch wait: ex_redirect=1, load_use=1 and imem_ready=0 in the same cycle.
  - Expect pc_en=1, pc_sel_redirect=1, ifid_flush=1, idex_flush=1.
  - flush_events increments by 1.
- Data wait: dmem_req=1 with dmem_ready=0 for 3 cycles, then 1.
  - Expect 3 frozen cycles (memwb_flush=1, exmem_en=0), then release on the 4th cycle.
  - A redirect held in EX during the freeze is applied on the release cycle.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0.
  - Expect mem_timeout=1 after 4 cycles and all enables held 0 thereafter.
  - rst=1 for one cycle returns to INIT with mem_timeout=0.
- Reset mid-operation: assert rst during MEM_WAIT with counters nonzero.
  - Expect all counters 0, INIT outputs for one cycle, then RUN.

Source files
------------

// File: rtl/rv32i_pipe_ctrl_if.sv
// Control bundle between the RV32I pipeline datapath and its hazard/sequencing controller.
// The controller attaches as slave; the datapath (or a bench) attaches as master.
interface rv32i_pipe_ctrl_if;
   logic [31:0] id_instr;
   logic        id_valid;
   logic        ex_valid;
   logic        ex_is_load;
   logic [4:0]  ex_rd;
   logic        ex_redirect;
   logic        imem_ready;
   logic        dmem_req;
   logic        dmem_ready;
   logic        pc_en;
   logic        pc_sel_redirect;
   logic        ifid_en;
   logic        ifid_flush;
   logic        idex_en;
   logic        idex_flush;
   logic        exmem_en;
   logic        memwb_flush;
   logic        mem_timeout;
   logic [31:0] stall_cycles;
   logic [31:0] flush_events;

   modport slave (
      input  id_instr, id_valid, ex_valid, ex_is_load, ex_rd, ex_redirect,
             imem_ready, dmem_req, dmem_ready,
      output pc_en, pc_sel_redirect, ifid_en, ifid_flush, idex_en, idex_flush,
             exmem_en, memwb_flush, mem_timeout, stall_cycles, flush_events
   );

   modport master (
      output id_instr, id_valid, ex_valid, ex_is_load, ex_rd, ex_redirect,
             imem_ready, dmem_req, dmem_ready,
      input  pc_en, pc_sel_redirect, ifid_en, ifid_flush, idex_en, idex_flush,
             exmem_en, memwb_flush, mem_timeout, stall_cycles, flush_events
   );
endinterface

// File: rtl/rv32i_pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline: load-use detection,
// stall/flush/freeze arbitration, data-memory timeout and performance counters.
module rv32i_pipe_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input logic              clk,
   input logic              rst,
   rv32i_pipe_ctrl_if.slave pif
);

   typedef enum logic [1:0] {INIT, RUN, MEM_WAIT, ERR} state_t;

   state_t      state, state_nx;
   logic [15:0] wait_cnt, wait_cnt_nx, wait_cnt_inc;
   logic        use_rs1, use_rs2, load_use;
   logic [4:0]  rs1, rs2;
   logic        pc_en, pc_sel_redirect, ifid_en, ifid_flush;
   logic        idex_en, idex_flush, exmem_en, memwb_flush, mem_timeout;
   logic [31:0] stall_cycles, flush_events;
   logic        unused_bits;

   assign rs1 = pif.id_instr[19:15];
   assign rs2 = pif.id_instr[24:20];
   assign unused_bits = ^{pif.id_instr[31:25], pif.id_instr[14:7]};

   always_comb begin
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      case (pif.id_instr[6:0])
         7'b0110011, 7'b0100011, 7'b1100011: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
         end
         7'b0010011, 7'b0000011, 7'b1100111: use_rs1 = 1'b1;
         default: ;
      endcase
   end

   assign load_use = pif.id_valid & pif.ex_valid & pif.ex_is_load & (pif.ex_rd != '0) &
                     ((use_rs1 & (rs1 == pif.ex_rd)) | (use_rs2 & (rs2 == pif.ex_rd)));

   // RUN entry counts as the first not-ready cycle, so the count starts at 1 there.
   assign wait_cnt_inc = (state == RUN) ? 16'd1 : wait_cnt + 16'd1;

   always_comb begin
      state_nx        = state;
      wait_cnt_nx     = wait_cnt;
      pc_en           = 1'b0;
      pc_sel_redirect = 1'b0;
      ifid_en         = 1'b0;
      ifid_flush      = 1'b0;
      idex_en         = 1'b0;
      idex_flush      = 1'b0;
      exmem_en        = 1'b0;
      memwb_flush     = 1'b0;
      mem_timeout     = 1'b0;
      if (rst || state == INIT) begin
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         memwb_flush = 1'b1;
         state_nx    = RUN;
      end else if (state == ERR) begin
         memwb_flush = 1'b1;
         mem_timeout = 1'b1;
      end else if (!pif.dmem_ready && (state == MEM_WAIT || pif.dmem_req)) begin
         memwb_flush = 1'b1;
         wait_cnt_nx = wait_cnt_inc;
         state_nx    = (32'(wait_cnt_inc) >= MEM_TIMEOUT) ? ERR : MEM_WAIT;
      end else begin
         // A redirect held in EX through a freeze resolves here on the release cycle.
         pc_en       = 1'b1;
         ifid_en     = 1'b1;
         idex_en     = 1'b1;
         exmem_en    = 1'b1;
         wait_cnt_nx = '0;
         state_nx    = RUN;
         if (pif.ex_redirect) begin
            pc_sel_redirect = 1'b1;
            ifid_flush      = 1'b1;
            idex_flush      = 1'b1;
         end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
         end else if (!pif.imem_ready) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= INIT;
         wait_cnt     <= '0;
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_cnt_nx;
         if (!pc_en)
            stall_cycles <= stall_cycles + 32'd1;
         if (pc_sel_redirect)
            flush_events <= flush_events + 32'd1;
      end
   end

   assign pif.pc_en           = pc_en;
   assign pif.pc_sel_redirect = pc_sel_redirect;
   assign pif.ifid_en         = ifid_en;
   assign pif.ifid_flush      = ifid_flush;
   assign pif.idex_en         = idex_en;
   assign pif.idex_flush      = idex_flush;
   assign pif.exmem_en        = exmem_en;
   assign pif.memwb_flush     = memwb_flush;
   assign pif.mem_timeout     = mem_timeout;
   assign pif.stall_cycles    = stall_cycles;
   assign pif.flush_events    = flush_events;

endmodule

// File: tb/tb_rv32i_pipe_ctrl.sv
// Scoreboard bench for rv32i_pipe_ctrl: directed per-cycle vectors push expected outputs,
// a negedge monitor pops and compares them against the controller.
module tb_rv32i_pipe_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rv32i_pipe_ctrl_if pif ();

   rv32i_pipe_ctrl #(.MEM_TIMEOUT(4)) dut (
      .clk (clk),
      .rst (rst),
      .pif (pif)
   );

   // {pc_en, pc_sel_redirect, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush, mem_timeout}
   localparam logic [8:0] O_INIT = 9'b000101010;
   localparam logic [8:0] O_RUN  = 9'b101010100;
   localparam logic [8:0] O_FRZ  = 9'b000000010;
   localparam logic [8:0] O_RDR  = 9'b111111100;
   localparam logic [8:0] O_LU   = 9'b000011100;
   localparam logic [8:0] O_FW   = 9'b001110100;
   localparam logic [8:0] O_ERR  = 9'b000000011;

   localparam logic [31:0] I_ADD  = 32'h00128333; // add x6,x5,x1
   localparam logic [31:0] I_LUI  = 32'h000052b7; // lui x5,5
   localparam logic [31:0] I_ADDI = 32'h00100313; // addi x6,x0,1
   localparam logic [31:0] I_SW   = 32'h0050a023; // sw x5,0(x1)
   localparam logic [31:0] I_JALR = 32'h00028067; // jalr x0,0(x5)
   localparam logic [31:0] I_NOP  = 32'h00000013;

   typedef struct {
      logic [8:0]  o;
      logic [31:0] st;
      logic [31:0] fl;
      int          id;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   int          step = 0;
   logic [31:0] exp_stall = '0;
   logic [31:0] exp_flush = '0;

   task automatic cyc(input logic r, input logic [31:0] instr, input logic ld,
                      input logic [4:0] rd, input logic redir, input logic imr,
                      input logic dreq, input logic drdy, input logic [8:0] o);
      exp_t e;
      rst             = r;
      pif.id_instr    = instr;
      pif.ex_is_load  = ld;
      pif.ex_rd       = rd;
      pif.ex_redirect = redir;
      pif.imem_ready  = imr;
      pif.dmem_req    = dreq;
      pif.dmem_ready  = drdy;
      e.o  = o;
      e.st = exp_stall;
      e.fl = exp_flush;
      e.id = step;
      sb.push_back(e);
      step++;
      if (r) begin
         exp_stall = '0;
         exp_flush = '0;
      end else begin
         if (!o[8]) exp_stall = exp_stall + 32'd1;
         if (o[7])  exp_flush = exp_flush + 32'd1;
      end
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         logic [8:0] act;
         e = sb.pop_front();
         act = {pif.pc_en, pif.pc_sel_redirect, pif.ifid_en, pif.ifid_flush, pif.idex_en,
                pif.idex_flush, pif.exmem_en, pif.memwb_flush, pif.mem_timeout};
         checks += 3;
         if (act !== e.o) begin
            failures++;
            $display("FAIL outputs step %0d: got %b want %b", e.id, act, e.o);
         end
         if (pif.stall_cycles !== e.st) begin
            failures++;
            $display("FAIL stall_cycles step %0d: got %0d want %0d", e.id, pif.stall_cycles, e.st);
         end
         if (pif.flush_events !== e.fl) begin
            failures++;
            $display("FAIL flush_events step %0d: got %0d want %0d", e.id, pif.flush_events, e.fl);
         end
      end
   end

   initial begin
      rst             = 1'b1;
      pif.id_instr    = I_NOP;
      pif.id_valid    = 1'b1;
      pif.ex_valid    = 1'b1;
      pif.ex_is_load  = 1'b0;
      pif.ex_rd       = '0;
      pif.ex_redirect = 1'b0;
      pif.imem_ready  = 1'b1;
      pif.dmem_req    = 1'b0;
      pif.dmem_ready  = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      //   rst   instr   ld    rd     rdr   imr   dreq  drdy  expected
      cyc(1'b0, I_NOP,  1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, O_INIT);
      cyc(1'b0, I_ADD,  1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, O_LU);   // rs1 load-use
      cyc(1'b0, I_ADD,  1'b0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, O_RUN);
      cyc(1'b0, I_LUI,  1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, O_RUN);  // no regs used
      cyc(1'b0, I_ADDI, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, O_RUN);  // x0 never hazards
      cyc(1'b0, I_SW,   1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, O_LU);   // rs2 load-use
      cyc(1'b0, I_JALR, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, O_LU);   // rs1-only opcode
      cyc(1'b0, I_JALR, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0, 1'b1, O_RUN);
      pif.id_valid = 1'b0;
      cyc(1'b0, I_ADD,  1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, O_RUN);  // bubble in ID
      pif.id_valid = 1'b1;
      cyc(1'b0, I_ADD,  1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, O_RDR);  // redirect wins
      cyc(1'b0, I_NOP,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, O_FW);   // fetch wait
      cyc(1'b0, I_NOP,  1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, O_FRZ);  // data wait 1
      cyc(1'b0, I_NOP,  1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, O_FRZ);  // data wait 2
      cyc(1'b0, I_NOP,  1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, O_FRZ);  // data wait 3
      cyc(1'b0, I_NOP,  1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, O_RDR);  // release + held redirect
      cyc(1'b0, I_NOP,  1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, O_RUN);
      cyc(1'b0, I_NOP,  1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, O_FRZ);
      cyc(1'b1, I_NOP,  1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, O_INIT); // reset mid-wait
      cyc(1'b0, I_NOP,  1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, O_INIT);
      cyc(1'b0, I_NOP,  1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, O_RUN);
      cyc(1'b0, I_NOP,  1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, O_FRZ);  // timeout run: 1
      cyc(1'b0, I_NOP,  1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, O_FRZ);  // 2
      cyc(1'b0, I_NOP,  1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, O_FRZ);  // 3
      cyc(1'b0, I_NOP,  1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, O_FRZ);  // 4
      cyc(1'b0, I_NOP,  1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, O_ERR);
      cyc(1'b0, I_ADD,  1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, O_ERR);  // ERR ignores everything
      cyc(1'b0, I_NOP,  1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, O_ERR);
      cyc(1'b1, I_NOP,  1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, O_INIT);
      cyc(1'b0, I_NOP,  1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, O_INIT);
      cyc(1'b0, I_NOP,  1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, O_RDR);
      cyc(1'b0, I_NOP,  1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, O_RUN);

      for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
      #1;
      if (sb.size() > 0) begin
         failures++;
         $display("FAIL drain: got %0d pending entries want 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
